// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and master state encoding
package spi_pkg;

    localparam int SPI_BITS         = 8;
    localparam int SPI_HALF_PERIODS = 2 * SPI_BITS;
    localparam int SPI_MIN_CLK_DIV  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_HOLD,
        ST_TRAIL,
        ST_GAP
    } spi_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 initiator, MSB first, single and multi-byte transactions
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                tx_last,
    output logic                ready,
    output logic                busy,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                spi_ssel,
    output logic                spi_sck,
    output logic                spi_mosi,
    input  logic                spi_miso
);

    localparam int              CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [3:0]      HALF_LAST = 4'(SPI_HALF_PERIODS - 1);
    localparam logic [3:0]      FALL_LAST = 4'(SPI_HALF_PERIODS - 2);

    generate
        if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_bad_div
            $error("spi_master: CLK_DIV must be at least 4");
        end
    endgenerate

    spi_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          half;
    logic [SPI_BITS-1:0] tx_sh;
    logic [SPI_BITS-1:0] rx_sh;
    logic                last_q;
    logic                miso_sync;
    logic                accept;
    logic                cnt_done;

    sync_2ff #(.WIDTH(1)) u_miso_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_miso),
        .q     (miso_sync)
    );

    assign accept   = start && ready;
    assign cnt_done = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            half     <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            last_q   <= 1'b0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            spi_ssel <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_LEAD;
                        cnt      <= '0;
                        tx_sh    <= tx_data;
                        last_q   <= tx_last;
                        spi_mosi <= tx_data[SPI_BITS-1];
                        spi_ssel <= 1'b0;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_LEAD: begin
                    if (cnt_done) begin
                        state   <= ST_SHIFT;
                        cnt     <= '0;
                        half    <= '0;
                        spi_sck <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Even half-periods are SCK high; sample in their final cycle.
                    if (!half[0] && cnt_done) begin
                        rx_sh <= {rx_sh[SPI_BITS-2:0], miso_sync};
                    end
                    if (!cnt_done) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (half == HALF_LAST) begin
                            rx_data  <= rx_sh;
                            rx_valid <= 1'b1;
                            if (last_q) begin
                                state <= ST_TRAIL;
                            end else begin
                                state <= ST_HOLD;
                                ready <= 1'b1;
                            end
                        end else begin
                            half    <= half + 4'd1;
                            spi_sck <= ~spi_sck;
                            // The 8th falling edge leaves bit 0 on the line.
                            if (!half[0] && half != FALL_LAST) begin
                                tx_sh    <= {tx_sh[SPI_BITS-2:0], 1'b0};
                                spi_mosi <= tx_sh[SPI_BITS-2];
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    // LEAD supplies the D-cycle SCK-low setup before the next byte.
                    if (accept) begin
                        state    <= ST_LEAD;
                        cnt      <= '0;
                        tx_sh    <= tx_data;
                        last_q   <= tx_last;
                        spi_mosi <= tx_data[SPI_BITS-1];
                        ready    <= 1'b0;
                    end
                end
                ST_TRAIL: begin
                    if (cnt_done) begin
                        state    <= ST_GAP;
                        cnt      <= '0;
                        spi_ssel <= 1'b1;
                        spi_mosi <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_done) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master
module tb_spi_master;

    localparam int D  = 4;
    localparam int D7 = 7;
    localparam logic [7:0] TGT_REPLY = 8'h3C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start7;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       ready, busy, rx_valid, spi_ssel, spi_sck, spi_mosi, spi_miso;
    logic [7:0] rx_data;
    logic       ready7, busy7, rx_valid7, ssel7, sck7, mosi7;
    logic [7:0] rx_data7;
    logic [1:0] miso_mode;

    logic [7:0] tgt_sh = 8'h00;
    logic [7:0] tgt_rx = 8'h00;
    logic       tgt_ssel_q = 1'b1;
    logic       tgt_sck_q = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    int cyc = 0, acc = 0, rel;
    int rise_cnt = 0, rxv_cnt = 0, ssel_rise_cnt = 0, hold_sck_bad = 0;
    int rxv_rel = 0, ssel_rise_rel = 0, ready_rise_rel = 0, first_rise_rel = 0;
    logic first_seen = 1'b0, busy_at_1 = 1'b0, ready_probe = 1'b0;
    logic sck_q = 1'b0, ssel_q = 1'b1, ready_q = 1'b1;
    logic [15:0] rx_hist = 16'h0;

    always #5 clk = ~clk;

    assign spi_miso = (miso_mode == 2'd0) ? spi_mosi :
                      (miso_mode == 2'd1) ? tgt_sh[7] :
                      (miso_mode == 2'd2);

    spi_master #(.CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .tx_last(tx_last),
        .ready(ready), .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid),
        .spi_ssel(spi_ssel), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_master #(.CLK_DIV(D7)) dut7 (
        .clk(clk), .rst_n(rst_n), .start(start7), .tx_data(tx_data), .tx_last(tx_last),
        .ready(ready7), .busy(busy7), .rx_data(rx_data7), .rx_valid(rx_valid7),
        .spi_ssel(ssel7), .spi_sck(sck7), .spi_mosi(mosi7), .spi_miso(1'b1)
    );

    // Mode-0 target: loads its reply on select, samples on rise, shifts on fall.
    always @(spi_ssel or spi_sck) begin
        if (tgt_ssel_q && !spi_ssel) begin
            tgt_sh = TGT_REPLY;
            tgt_rx = 8'h00;
        end else if (!spi_ssel && !tgt_sck_q && spi_sck) begin
            tgt_rx = {tgt_rx[6:0], spi_mosi};
        end else if (!spi_ssel && tgt_sck_q && !spi_sck) begin
            tgt_sh = {tgt_sh[6:0], 1'b0};
        end
        tgt_ssel_q = spi_ssel;
        tgt_sck_q  = spi_sck;
    end

    assign rel = (start && ready) ? 0 : cyc - acc;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (start && ready) begin
            acc        <= cyc;
            first_seen <= 1'b0;
        end
        if (spi_sck && !sck_q) begin
            rise_cnt <= rise_cnt + 1;
            if (!first_seen) begin
                first_rise_rel <= rel;
                first_seen     <= 1'b1;
            end
        end
        if (rx_valid) begin
            rxv_cnt <= rxv_cnt + 1;
            rxv_rel <= rel;
            rx_hist <= {rx_hist[7:0], rx_data};
        end
        if (spi_ssel && !ssel_q) begin
            ssel_rise_cnt <= ssel_rise_cnt + 1;
            ssel_rise_rel <= rel;
        end
        if (ready && !ready_q) ready_rise_rel <= rel;
        if (rel == 1) busy_at_1 <= busy;
        if (rel == 17 * D + 2) ready_probe <= ready;
        if (ready && !spi_ssel && spi_sck) hold_sck_bad <= hold_sck_bad + 1;
        sck_q   <= spi_sck;
        ssel_q  <= spi_ssel;
        ready_q <= ready;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        start   = 1'b1;
        tx_data = b;
        tx_last = last;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 400) begin
            tick();
            n++;
        end
        chk({"ready timeout ", name}, 32'(ready), 32'd1);
    endtask

    task automatic wait_rises(input int n, input int base);
        int k = 0;
        while (rise_cnt - base < n && k < 400) begin
            tick();
            k++;
        end
        chk("rise wait timeout", 32'(rise_cnt - base >= n), 32'd1);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [1:0] mode;
        logic [7:0] exp_rx;
        logic [7:0] exp_tgt;
        int         exp_rxv;
        int         exp_ssel;
        int         exp_rdy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int b_r, b_v, b_s, b_h;
        int v7_rel, v7_cnt, r7, s7_rel, rdy7_rel;
        logic [7:0] v7_data;
        logic p_sck, p_ssel, p_rdy;

        // mode: 0 loopback, 1 target model, 2 miso=1, 3 miso=0
        vecs[0] = '{8'hA5, 2'd0, 8'hA5, 8'hA5, 69, 73, 77};
        vecs[1] = '{8'hC3, 2'd1, 8'h3C, 8'hC3, 69, 73, 77};
        vecs[2] = '{8'h00, 2'd0, 8'h00, 8'h00, 69, 73, 77};
        vecs[3] = '{8'hFF, 2'd3, 8'h00, 8'hFF, 69, 73, 77};
        vecs[4] = '{8'h5A, 2'd2, 8'hFF, 8'h5A, 69, 73, 77};
        vecs[5] = '{8'h81, 2'd1, 8'h3C, 8'h81, 69, 73, 77};

        rst_n = 1'b0; start = 1'b0; start7 = 1'b0;
        tx_data = 8'h00; tx_last = 1'b0; miso_mode = 2'd0;
        repeat (3) tick();
        chk("reset ssel", 32'(spi_ssel), 32'd1);
        chk("reset sck", 32'(spi_sck), 32'd0);
        chk("reset mosi", 32'(spi_mosi), 32'd0);
        chk("reset rx_data", 32'(rx_data), 32'd0);
        chk("reset rx_valid", 32'(rx_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ready", 32'(ready), 32'd1);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            b_r = rise_cnt;
            b_v = rxv_cnt;
            miso_mode = vecs[i].mode;
            tick();
            send(vecs[i].tx, 1'b1);
            wait_ready("vec");
            repeat (3) tick();
            chk($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
            chk($sformatf("vec%0d target rx", i), 32'(tgt_rx), 32'(vecs[i].exp_tgt));
            chk($sformatf("vec%0d rx_valid count", i), rxv_cnt - b_v, 32'd1);
            chk($sformatf("vec%0d rx_valid cycle", i), rxv_rel, vecs[i].exp_rxv);
            chk($sformatf("vec%0d ssel rise cycle", i), ssel_rise_rel, vecs[i].exp_ssel);
            chk($sformatf("vec%0d ready rise cycle", i), ready_rise_rel, vecs[i].exp_rdy);
            chk($sformatf("vec%0d sck rises", i), rise_cnt - b_r, 32'd8);
            chk($sformatf("vec%0d first rise cycle", i), first_rise_rel, 1 + D);
            chk($sformatf("vec%0d busy at cycle 1", i), 32'(busy_at_1), 32'd1);
            chk($sformatf("vec%0d idle busy", i), 32'(busy), 32'd0);
            chk($sformatf("vec%0d idle mosi", i), 32'(spi_mosi), 32'd0);
        end

        // Two-byte transaction with select held low through HOLD.
        miso_mode = 2'd0;
        b_r = rise_cnt; b_v = rxv_cnt; b_s = ssel_rise_cnt; b_h = hold_sck_bad;
        tick();
        send(8'h01, 1'b0);
        wait_ready("hold");
        repeat (5) tick();
        chk("hold ready at 17D+2", 32'(ready_probe), 32'd1);
        chk("hold ssel", 32'(spi_ssel), 32'd0);
        chk("hold sck", 32'(spi_sck), 32'd0);
        chk("hold first rx", 32'(rx_data), 32'h01);
        send(8'h02, 1'b1);
        wait_ready("multi");
        repeat (3) tick();
        chk("multi sck rises", rise_cnt - b_r, 32'd16);
        chk("multi rx_valid count", rxv_cnt - b_v, 32'd2);
        chk("multi rx history", 32'(rx_hist), 32'h0102);
        chk("multi ssel rise count", ssel_rise_cnt - b_s, 32'd1);
        chk("multi sck high in hold", hold_sck_bad - b_h, 32'd0);
        chk("multi first rise after hold accept", first_rise_rel, 1 + D);
        chk("multi ssel rise cycle", ssel_rise_rel, 32'd73);

        // Start during SHIFT must be dropped, not queued.
        b_r = rise_cnt; b_v = rxv_cnt;
        tick();
        send(8'h11, 1'b1);
        wait_rises(2, b_r);
        start = 1'b1; tx_data = 8'hFF; tx_last = 1'b1;
        chk("ignored start ready", 32'(ready), 32'd0);
        tick();
        start = 1'b0;
        wait_ready("ignored");
        repeat (40) tick();
        chk("ignored rx_data", 32'(rx_data), 32'h11);
        chk("ignored target rx", 32'(tgt_rx), 32'h11);
        chk("ignored rx_valid count", rxv_cnt - b_v, 32'd1);
        chk("ignored sck rises", rise_cnt - b_r, 32'd8);
        chk("ignored ready rise cycle", ready_rise_rel, 32'd77);

        // Asynchronous reset after the third rising edge.
        b_r = rise_cnt; b_v = rxv_cnt;
        send(8'h5A, 1'b1);
        wait_rises(3, b_r);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset ssel", 32'(spi_ssel), 32'd1);
        chk("midreset sck", 32'(spi_sck), 32'd0);
        chk("midreset mosi", 32'(spi_mosi), 32'd0);
        chk("midreset ready", 32'(ready), 32'd1);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset rx_data", 32'(rx_data), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("midreset no rx_valid", rxv_cnt - b_v, 32'd0);
        b_r = rise_cnt;
        send(8'h96, 1'b1);
        wait_ready("after reset");
        repeat (3) tick();
        chk("after reset rx_data", 32'(rx_data), 32'h96);
        chk("after reset target rx", 32'(tgt_rx), 32'h96);
        chk("after reset sck rises", rise_cnt - b_r, 32'd8);
        chk("after reset rx_valid cycle", rxv_rel, 32'd69);

        // CLK_DIV=7 instance with MISO tied high.
        tx_data = 8'h00; tx_last = 1'b1;
        start7 = 1'b1;
        tick();
        start7 = 1'b0;
        v7_rel = -1; v7_cnt = 0; r7 = 0; s7_rel = -1; rdy7_rel = -1; v7_data = 8'h00;
        p_sck = sck7; p_ssel = ssel7; p_rdy = ready7;
        for (int k = 1; k < 400 && rdy7_rel < 0; k++) begin
            if (rx_valid7) begin
                v7_cnt++;
                v7_rel  = k;
                v7_data = rx_data7;
            end
            if (sck7 && !p_sck) r7++;
            if (ssel7 && !p_ssel) s7_rel = k;
            if (ready7 && !p_rdy) rdy7_rel = k;
            p_sck = sck7; p_ssel = ssel7; p_rdy = ready7;
            tick();
        end
        chk("d7 rx_valid cycle", v7_rel, 32'd120);
        chk("d7 rx_data", 32'(v7_data), 32'hFF);
        chk("d7 rx_valid count", v7_cnt, 32'd1);
        chk("d7 ssel rise cycle", s7_rel, 32'd127);
        chk("d7 ready rise cycle", rdy7_rel, 32'd134);
        chk("d7 sck rises", r7, 32'd8);
        chk("d7 idle busy", 32'(busy7), 32'd0);
        chk("d7 idle mosi", 32'(mosi7), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
